load_store_buffer: RTL

In-order memory queue between the decoder/reorder buffer and the memory controller. Accepts load/store micro-ops at issue, snoops the CDB (ALU and own broadcast) for missing operands, executes the head entry against memory, and broadcasts load results on the LSB side of the CDB. Stores touch memory only after the reorder buffer commits their tag. On rollback, uncommitted entries are discarded and committed stores drain.

---
 rtl/load_store_buffer_pkg.sv | 37 +++
 rtl/lsb_load_extend.sv | 23 ++
 rtl/load_store_buffer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_buffer_pkg.sv
// Shared constants and helpers for the load/store buffer.
// Opcodes, funct3 codes, null tag, access size encodings, FSM states.
package load_store_buffer_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned NULL_TAG = 0;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } lsb_state_t;

  function automatic logic [1:0] size_of(
    input logic [2:0] f3
  );
    logic [1:0] s;
    unique case (f3[1:0])
      2'b00:   s = SZ_BYTE;
      2'b01:   s = SZ_HALF;
      default: s = SZ_WORD;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsb_load_extend.sv
// Load result extension: sign/zero extend byte and half loads.
// Only the low bits of the memory data are meaningful.
module lsb_load_extend
  import load_store_buffer_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  always_comb begin
    result = rdata;
    unique case (funct3)
      F3_LB:   result = {{24{rdata[7]}}, rdata[7:0]};
      F3_LH:   result = {{16{rdata[15]}}, rdata[15:0]};
      F3_LBU:  result = {24'd0, rdata[7:0]};
      F3_LHU:  result = {16'd0, rdata[15:0]};
      F3_LW:   result = rdata;
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue: issue, CDB snoop, commit tracking,
// one memory transaction at a time, load results on the LSB CDB.
module load_store_buffer
  import load_store_buffer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rollback_in,
  output logic             full_out,
  input  logic             dec_issue_in,
  input  logic [31:0]      dec_inst_in,
  input  logic [TAG_W-1:0] dec_tag_in,
  input  logic [31:0]      dec_Vj_in,
  input  logic [31:0]      dec_Vk_in,
  input  logic [TAG_W-1:0] dec_Qj_in,
  input  logic [TAG_W-1:0] dec_Qk_in,
  input  logic [31:0]      dec_imm_in,
  input  logic             alu_broadcast_signal_in,
  input  logic [31:0]      alu_result_in,
  input  logic [TAG_W-1:0] alu_dest_tag_in,
  input  logic             commit_signal_in,
  input  logic [TAG_W-1:0] commit_tag_in,
  output logic             mem_req_out,
  output logic             mem_we_out,
  output logic [31:0]      mem_addr_out,
  output logic [1:0]       mem_size_out,
  output logic [31:0]      mem_wdata_out,
  input  logic             mem_done_in,
  input  logic [31:0]      mem_rdata_in,
  output logic             lsb_broadcast_signal_out,
  output logic [31:0]      lsb_result_out,
  output logic [TAG_W-1:0] lsb_dest_tag_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [TAG_W-1:0] NT = TAG_W'(NULL_TAG);

  typedef struct packed {
    logic             is_store;
    logic [2:0]       funct3;
    logic [31:0]      vj;
    logic [TAG_W-1:0] qj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qk;
    logic [31:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             committed;
  } entry_t;

  entry_t           ent   [DEPTH];
  entry_t           ent_n [DEPTH];
  entry_t           hd;
  entry_t           ins;
  logic [DEPTH-1:0] vld, vld_n;
  logic [PW-1:0]    head, tail, head_n, tail_n;
  logic [PW-1:0]    idx, off;
  logic [CW-1:0]    count, count_n, ccnt;
  logic             run;
  lsb_state_t       state, state_n;
  logic             start, done, pop, push, head_ok;
  logic             drop, cur_store;
  logic [2:0]       cur_f3;
  logic [TAG_W-1:0] cur_tag;
  logic             pend;
  logic [31:0]      pend_data, ext;
  logic [2:0]       pend_f3;
  logic [TAG_W-1:0] pend_tag;
  logic             unused_inst;

  assign unused_inst = ^{dec_inst_in[31:15], dec_inst_in[11:7]};

  function automatic logic [TAG_W+31:0] grab(
    input logic [31:0]      v,
    input logic [TAG_W-1:0] q
  );
    logic [TAG_W+31:0] r;
    r = {v, q};
    if (q != NT) begin
      if (alu_broadcast_signal_in && q == alu_dest_tag_in)
        r = {alu_result_in, NT};
      else if (lsb_broadcast_signal_out && q == lsb_dest_tag_out)
        r = {lsb_result_out, NT};
    end
    return r;
  endfunction

  assign full_out = (count == CW'(DEPTH));
  assign push     = dec_issue_in & ~full_out & ~rollback_in;
  assign hd       = ent[head];
  assign head_ok  = vld[head] && hd.qj == NT &&
                    (!hd.is_store || (hd.qk == NT && hd.committed));
  assign done     = state == S_WAIT && mem_done_in && !drop;
  // A load finishing in the rollback cycle was discarded by the flush.
  assign pop      = done && (cur_store || !rollback_in);

  always_comb begin
    ins           = '0;
    ins.is_store  = dec_inst_in[6:0] == OP_STORE;
    ins.funct3    = dec_inst_in[14:12];
    {ins.vj, ins.qj} = grab(dec_Vj_in, dec_Qj_in);
    {ins.vk, ins.qk} = grab(dec_Vk_in, dec_Qk_in);
    ins.imm       = dec_imm_in;
    ins.tag       = dec_tag_in;
    ins.committed = commit_signal_in && commit_tag_in == dec_tag_in;
  end

  always_comb begin
    ent_n = ent;
    vld_n = vld;
    ccnt  = '0;
    run   = 1'b1;
    idx   = '0;
    off   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (run && vld[idx] && ent[idx].committed)
        ccnt = ccnt + CW'(1);
      else
        run = 1'b0;
    end
    if (!rollback_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        {ent_n[i].vj, ent_n[i].qj} = grab(ent[i].vj, ent[i].qj);
        {ent_n[i].vk, ent_n[i].qk} = grab(ent[i].vk, ent[i].qk);
        if (commit_signal_in && vld[i] &&
            ent[i].tag == commit_tag_in)
          ent_n[i].committed = 1'b1;
      end
      if (push) begin
        ent_n[tail] = ins;
        vld_n[tail] = 1'b1;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        off = PW'(i) - head;
        if ({1'b0, off} >= ccnt) vld_n[i] = 1'b0;
      end
    end
    if (pop) vld_n[head] = 1'b0;
  end

  always_comb begin
    head_n = head + PW'(pop);
    if (rollback_in) begin
      tail_n  = head + ccnt[PW-1:0];
      count_n = ccnt - CW'(pop);
    end else begin
      tail_n  = tail + PW'(push);
      count_n = count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    unique case (state)
      S_IDLE: if (head_ok && !rollback_in) begin
        start   = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: if (mem_done_in) state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  lsb_load_extend u_ext (
    .rdata  (pend_data),
    .funct3 (pend_f3),
    .result (ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      vld       <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      drop      <= 1'b0;
      cur_store <= 1'b0;
      cur_f3    <= '0;
      cur_tag   <= '0;
      pend      <= 1'b0;
      pend_data <= '0;
      pend_f3   <= '0;
      pend_tag  <= '0;
      mem_req_out   <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_size_out  <= '0;
      mem_wdata_out <= '0;
      lsb_broadcast_signal_out <= 1'b0;
      lsb_result_out   <= '0;
      lsb_dest_tag_out <= '0;
    end else begin
      ent   <= ent_n;
      vld   <= vld_n;
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
      if (start) begin
        mem_req_out   <= 1'b1;
        mem_we_out    <= hd.is_store;
        mem_addr_out  <= hd.vj + hd.imm;
        mem_size_out  <= size_of(hd.funct3);
        mem_wdata_out <= hd.vk;
        cur_store     <= hd.is_store;
        cur_f3        <= hd.funct3;
        cur_tag       <= hd.tag;
      end else if (state == S_WAIT && mem_done_in) begin
        mem_req_out <= 1'b0;
      end
      if (state == S_WAIT && mem_done_in)
        drop <= 1'b0;
      else if (state == S_WAIT && rollback_in && !cur_store)
        drop <= 1'b1;
      pend <= done && !cur_store && !rollback_in;
      if (done && !cur_store) begin
        pend_data <= mem_rdata_in;
        pend_f3   <= cur_f3;
        pend_tag  <= cur_tag;
      end
      lsb_broadcast_signal_out <= pend;
      if (pend) begin
        lsb_result_out   <= ext;
        lsb_dest_tag_out <= pend_tag;
      end
    end
  end

endmodule
